// File: rtl/wb_regfile.sv
// Writeback stage register file: selects ALU/load writeback data, commits it to a
// 2**ADDR_W x DATA_W array, and serves two bypassed read ports after a clear sweep.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              init_busy,
  output logic              dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic [DATA_W-1:0]   wb_wdata;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wval;
  logic                reads_blocked;

  assign wb_wdata    = wb_mem_to_reg ? mem_data : alu_res;
  assign init_busy   = (state_q == ST_INIT);
  assign dbg_state_o = state_q;

  // Clear sweep: one register per cycle, leave INIT after the last index.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_INIT;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Single write port shared by the clear sweep and pipeline writeback.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wval  = '0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        we    = 1'b1;
        waddr = clr_cnt_q;
      end else if (wb_valid && (wb_dst != '0)) begin
        we    = 1'b1;
        waddr = wb_dst;
        wval  = wb_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      regs_q[waddr] <= wval;
    end
  end

  assign reads_blocked = rst || (state_q == ST_INIT);

  // R0 reads as zero; a same-cycle writeback to the read index is forwarded.
  always_comb begin
    rd_data1 = '0;
    if (!reads_blocked && (rd_addr1 != '0)) begin
      if (wb_valid && (wb_dst == rd_addr1)) begin
        rd_data1 = wb_wdata;
      end else begin
        rd_data1 = regs_q[rd_addr1];
      end
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (!reads_blocked && (rd_addr2 != '0)) begin
      if (wb_valid && (wb_dst == rd_addr2)) begin
        rd_data2 = wb_wdata;
      end else begin
        rd_data2 = regs_q[rd_addr2];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: clear sequence, table-driven writeback/bypass
// vectors, randomized traffic against a register model, and a mid-INIT reset.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  wb_dst;
  logic        wb_mem_to_reg;
  logic [15:0] alu_res;
  logic [15:0] mem_data;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        init_busy;
  logic        dbg_state;

  int n_checks;
  int n_pass;

  logic [15:0] exp_q[$];
  logic [15:0] model [16];

  typedef struct {
    logic        wv;
    logic [3:0]  dst;
    logic        m2r;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vecs [13];

  wb_regfile #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_dst        (wb_dst),
    .wb_mem_to_reg (wb_mem_to_reg),
    .alu_res       (alu_res),
    .mem_data      (mem_data),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2),
    .init_busy     (init_busy),
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_valid      = 1'b0;
    wb_dst        = 4'd0;
    wb_mem_to_reg = 1'b0;
    alu_res       = 16'h0;
    mem_data      = 16'h0;
  endtask

  function automatic logic [15:0] model_rd(input logic [3:0] a, input logic wv,
                                           input logic [3:0] dst, input logic [15:0] wd);
    if (a == 4'd0) return 16'h0;
    if (wv && dst == a) return wd;
    return model[a];
  endfunction

  // Driver: one RUN cycle; expected reads queued at drive, popped at sample.
  task automatic apply(input vec_t v, input string tag);
    logic [15:0] e;
    @(negedge clk);
    wb_valid      = v.wv;
    wb_dst        = v.dst;
    wb_mem_to_reg = v.m2r;
    alu_res       = v.alu;
    mem_data      = v.mem;
    rd_addr1      = v.a1;
    rd_addr2      = v.a2;
    exp_q.push_back(v.e1);
    exp_q.push_back(v.e2);
    #2;
    e = exp_q.pop_front();
    check({tag, "_rd1"}, rd_data1, e);
    e = exp_q.pop_front();
    check({tag, "_rd2"}, rd_data2, e);
    if (v.wv && v.dst != 4'd0) model[v.dst] = v.m2r ? v.mem : v.alu;
  endtask

  // Expects rst already low at the current negedge; walks the 16 INIT cycles.
  task automatic expect_init_sweep(input string tag, input logic [3:0] probe);
    rd_addr1 = probe;
    rd_addr2 = probe;
    for (int i = 0; i < 16; i++) begin
      #1;
      check({tag, "_busy"}, 16'(init_busy), 16'h1);
      check({tag, "_init_rd1"}, rd_data1, 16'h0);
      @(negedge clk);
    end
    #1;
    check({tag, "_busy_done"}, 16'(init_busy), 16'h0);
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    rd_addr1 = 4'd0;
    rd_addr2 = 4'd0;
    idle_inputs();

    vecs[0]  = '{1'b1, 4'd3,  1'b0, 16'hBEEF, 16'h0000, 4'd3,  4'd0,  16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000, 4'd3,  4'd3,  16'hBEEF, 16'hBEEF};
    vecs[2]  = '{1'b1, 4'd5,  1'b1, 16'hFFFF, 16'h1234, 4'd5,  4'd5,  16'h1234, 16'h1234};
    vecs[3]  = '{1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000, 4'd5,  4'd3,  16'h1234, 16'hBEEF};
    vecs[4]  = '{1'b1, 4'd0,  1'b0, 16'hAAAA, 16'h0000, 4'd0,  4'd3,  16'h0000, 16'hBEEF};
    vecs[5]  = '{1'b0, 4'd0,  1'b0, 16'hAAAA, 16'h0000, 4'd0,  4'd5,  16'h0000, 16'h1234};
    vecs[6]  = '{1'b1, 4'd5,  1'b0, 16'h0F0F, 16'h7777, 4'd5,  4'd4,  16'h0F0F, 16'h0000};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000, 4'd5,  4'd7,  16'h0F0F, 16'h0000};
    vecs[8]  = '{1'b1, 4'd15, 1'b1, 16'h0000, 16'hC3C3, 4'd15, 4'd14, 16'hC3C3, 16'h0000};
    vecs[9]  = '{1'b1, 4'd14, 1'b0, 16'h0001, 16'h9999, 4'd15, 4'd14, 16'hC3C3, 16'h0001};
    vecs[10] = '{1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000, 4'd14, 4'd15, 16'h0001, 16'hC3C3};
    vecs[11] = '{1'b1, 4'd3,  1'b0, 16'h1111, 16'h0000, 4'd5,  4'd15, 16'h0F0F, 16'hC3C3};
    vecs[12] = '{1'b0, 4'd0,  1'b0, 16'h0000, 16'h0000, 4'd3,  4'd0,  16'h1111, 16'h0000};

    // Reset held; a writeback to R7 is presented throughout INIT and must not commit.
    repeat (2) @(negedge clk);
    rd_addr1 = 4'd5;
    #1;
    check("rst_busy", 16'(init_busy), 16'h1);
    check("rst_rd1", rd_data1, 16'h0);
    wb_valid = 1'b1;
    wb_dst   = 4'd7;
    alu_res  = 16'h7777;
    @(negedge clk);
    rst = 1'b0;
    expect_init_sweep("init1", 4'd7);
    idle_inputs();

    for (int i = 1; i < 16; i++) begin
      rd_addr1 = 4'(i);
      rd_addr2 = 4'(16 - i);
      #1;
      check("clr_rd1", rd_data1, 16'h0);
      check("clr_rd2", rd_data2, 16'h0);
    end

    for (int i = 0; i < 13; i++) apply(vecs[i], "tbl");

    for (int i = 0; i < 40; i++) begin
      logic [15:0] wd;
      v.wv  = 1'($urandom_range(0, 1));
      v.dst = 4'($urandom_range(0, 15));
      v.m2r = 1'($urandom_range(0, 1));
      v.alu = 16'($urandom_range(0, 65535));
      v.mem = 16'($urandom_range(0, 65535));
      v.a1  = 4'($urandom_range(0, 15));
      v.a2  = ($urandom_range(0, 3) == 0) ? v.dst : 4'($urandom_range(0, 15));
      wd    = v.m2r ? v.mem : v.alu;
      v.e1  = model_rd(v.a1, v.wv, v.dst, wd);
      v.e2  = model_rd(v.a2, v.wv, v.dst, wd);
      apply(v, "rnd");
    end

    // Write R9, then reset and re-reset partway through the clear sweep.
    apply('{1'b1, 4'd9, 1'b0, 16'h5555, 16'h0000, 4'd9, 4'd9, 16'h5555, 16'h5555}, "r9w");
    apply('{1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000, 4'd9, 4'd0, 16'h5555, 16'h0000}, "r9r");
    @(negedge clk);
    idle_inputs();
    rd_addr1 = 4'd9;
    rst = 1'b1;
    #1;
    check("rst_comb_rd1", rd_data1, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("mid_busy", 16'(init_busy), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_init_sweep("init2", 4'd9);
    rd_addr1 = 4'd9;
    rd_addr2 = 4'd9;
    #1;
    check("r9_cleared1", rd_data1, 16'h0);
    check("r9_cleared2", rd_data2, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
